// File: rtl/approximate_pipelined_subtractor_pkg.sv
// rtl/approximate_pipelined_subtractor_pkg.sv - cell equations and parameter legality for the approximate subtractor
package approximate_pipelined_subtractor_pkg;

   localparam int DEFAULT_LEN     = 32;
   localparam int DEFAULT_APX_LEN = 8;

   // Meaning of one accuracy-control bit.
   typedef enum logic {
      CELL_APPROX = 1'b0,
      CELL_EXACT  = 1'b1
   } cell_mode_e;

   // Exact full adder.
   function automatic logic fa_exact_sum(input logic a, input logic b, input logic c);
      return a ^ b ^ c;
   endfunction

   function automatic logic fa_exact_cout(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Error-configurable full adder; e = 1 reduces it to the exact cell,
   // e = 0 gives sum = (a^b)|c and cout = a & (b|c).
   function automatic logic fa_cfg_sum(input logic e, input logic a, input logic b, input logic c);
      return ~(e & (a ^ b) & c) & ((a ^ b) | c);
   endfunction

   function automatic logic fa_cfg_cout(input logic e, input logic a, input logic b, input logic c);
      return (e & b & c) | ((b | c) & a);
   endfunction

   // Width legality: LEN even and at least 8, 0 < APX_LEN <= LEN.
   function automatic bit params_legal(input int len, input int apx_len);
      return (len >= 8) && ((len % 2) == 0) && (apx_len > 0) && (apx_len <= len);
   endfunction

endpackage

// File: rtl/approximate_pipelined_subtractor_sub_slice.sv
// rtl/approximate_pipelined_subtractor_sub_slice.sv - parameterised ripple slice of A + ~B with per-bit accuracy control
module approximate_sub_slice
   import approximate_pipelined_subtractor_pkg::*;
#(
   parameter int WIDTH     = 16,
   parameter int ER_OFFSET = 0,
   parameter int APX_LEN   = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b_n,
   input  logic [WIDTH-1:0] er,
   input  logic             carry_in,
   output logic [WIDTH-1:0] sum,
   output logic             carry_out
);

   logic carry;
   logic e;

   // Ripple the chain; positions at or above APX_LEN (in global numbering)
   // are forced to the exact cell regardless of the er bit presented.
   always_comb begin
      sum   = '0;
      carry = carry_in;
      e     = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         e      = ((ER_OFFSET + i) >= APX_LEN) ? logic'(CELL_EXACT) : er[i];
         sum[i] = fa_cfg_sum(e, a[i], b_n[i], carry);
         carry  = fa_cfg_cout(e, a[i], b_n[i], carry);
      end
      carry_out = carry;
   end

endmodule

// File: rtl/approximate_pipelined_subtractor.sv
// rtl/approximate_pipelined_subtractor.sv - two-stage valid/ready approximate subtractor, Diff = A + ~B + 1
module approximate_pipelined_subtractor
   import approximate_pipelined_subtractor_pkg::*;
#(
   parameter int LEN     = DEFAULT_LEN,
   parameter int APX_LEN = DEFAULT_APX_LEN
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LEN-1:0]     A,
   input  logic [LEN-1:0]     B,
   input  logic [APX_LEN-1:0] Er,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [LEN-1:0]     Diff,
   output logic               Borrow
);

   localparam int SPLIT = LEN / 2;
   localparam int HI    = LEN - SPLIT;

   if (!params_legal(LEN, APX_LEN)) begin : g_illegal_params
      $error("approximate_pipelined_subtractor: LEN must be even and >= 8, 0 < APX_LEN <= LEN");
   end

   // Accuracy control widened to the full datapath; exact positions read 1.
   logic [LEN-1:0] er_ext;
   for (genvar i = 0; i < LEN; i++) begin : g_er_ext
      if (i < APX_LEN) begin : g_cfg
         assign er_ext[i] = Er[i];
      end else begin : g_exact
         assign er_ext[i] = 1'b1;
      end
   end

   logic [LEN-1:0] b_n;
   assign b_n = ~B;

   // Stage-1 state: low half result plus everything stage 2 needs.
   logic             s1_valid;
   logic [SPLIT-1:0] s1_sum_lo;
   logic             s1_carry;
   logic [HI-1:0]    s1_a_hi;
   logic [HI-1:0]    s1_b_n_hi;
   logic [HI-1:0]    s1_er_hi;

   logic [SPLIT-1:0] s1_sum_next;
   logic             s1_carry_next;
   logic [HI-1:0]    s2_sum_next;
   logic             s2_carry_next;

   logic s2_valid;
   logic s2_free;
   logic s2_load;

   // Stage 2 can take new data when empty or when its result leaves now;
   // stage 1 can take new data when empty or when it drains into stage 2.
   assign s2_free   = ~s2_valid | out_ready;
   assign s2_load   = s1_valid & s2_free;
   assign in_ready  = ~s1_valid | s2_free;
   assign out_valid = s2_valid;

   approximate_sub_slice #(
      .WIDTH     (SPLIT),
      .ER_OFFSET (0),
      .APX_LEN   (APX_LEN)
   ) u_stage1 (
      .a         (A[SPLIT-1:0]),
      .b_n       (b_n[SPLIT-1:0]),
      .er        (er_ext[SPLIT-1:0]),
      .carry_in  (1'b1),
      .sum       (s1_sum_next),
      .carry_out (s1_carry_next)
   );

   approximate_sub_slice #(
      .WIDTH     (HI),
      .ER_OFFSET (SPLIT),
      .APX_LEN   (APX_LEN)
   ) u_stage2 (
      .a         (s1_a_hi),
      .b_n       (s1_b_n_hi),
      .er        (s1_er_hi),
      .carry_in  (s1_carry),
      .sum       (s2_sum_next),
      .carry_out (s2_carry_next)
   );

   // Stage 1: capture operands, Er and the low half on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid  <= 1'b0;
         s1_sum_lo <= '0;
         s1_carry  <= 1'b0;
         s1_a_hi   <= '0;
         s1_b_n_hi <= '0;
         s1_er_hi  <= '1;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_sum_lo <= s1_sum_next;
            s1_carry  <= s1_carry_next;
            s1_a_hi   <= A[LEN-1:SPLIT];
            s1_b_n_hi <= b_n[LEN-1:SPLIT];
            s1_er_hi  <= er_ext[LEN-1:SPLIT];
         end
      end
   end

   // Stage 2: finish the high half and hold the result until consumed.
   always_ff @(posedge clk) begin
      if (reset) begin
         s2_valid <= 1'b0;
         Diff     <= '0;
         Borrow   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= 1'b1;
         Diff     <= {s2_sum_next, s1_sum_lo};
         Borrow   <= ~s2_carry_next;
      end else if (out_ready) begin
         s2_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_approximate_pipelined_subtractor.sv
// tb/tb_approximate_pipelined_subtractor.sv - table and scoreboard bench for approximate_pipelined_subtractor
module tb_approximate_pipelined_subtractor;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  er;
      logic [31:0] diff;
      logic        borrow;
   } vec_t;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] A;
   logic [31:0] B;
   logic [7:0]  Er;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] Diff;
   logic        Borrow;

   int   errors;
   int   checks;
   vec_t sb_q[$];
   vec_t exp_in;
   vec_t vecs[8];
   bit   rand_ready_en;

   approximate_pipelined_subtractor #(
      .LEN     (32),
      .APX_LEN (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Er        (Er),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Diff      (Diff),
      .Borrow    (Borrow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compares each consumed result with the oldest expectation and records
   // expectations as transactions are accepted.
   task automatic monitor_loop();
      vec_t e;
      forever begin
         @(negedge clk);
         if (reset) begin
            sb_q.delete();
         end else begin
            if (out_valid) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL stale_output: got Diff=%h Borrow=%b with nothing outstanding", Diff, Borrow);
               end else if (out_ready) begin
                  e = sb_q.pop_front();
                  check("sb_diff", Diff, e.diff);
                  check("sb_borrow", {31'd0, Borrow}, {31'd0, e.borrow});
               end
            end
            if (in_valid && in_ready) sb_q.push_back(exp_in);
         end
      end
   endtask

   task automatic random_ready_loop();
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready_en) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic drive(input vec_t v);
      in_valid = 1'b1;
      A        = v.a;
      B        = v.b;
      Er       = v.er;
      exp_in   = v;
   endtask

   // Offer one transaction and return just after the edge that accepts it.
   task automatic send(input vec_t v);
      int n;
      drive(v);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] er,
                               input logic [31:0] d, input logic bo);
      vec_t v;
      v.a = a; v.b = b; v.er = er; v.diff = d; v.borrow = bo;
      return v;
   endfunction

   initial begin
      int n;
      vec_t v;
      errors        = 0;
      checks        = 0;
      rand_ready_en = 1'b0;
      reset         = 1'b1;
      in_valid      = 1'b0;
      out_ready     = 1'b1;
      A             = '0;
      B             = '0;
      Er            = 8'hFF;
      exp_in        = mk(0, 0, 0, 0, 0);

      vecs[0] = mk(32'd10,         32'd3,          8'hFF, 32'd7,          1'b0);
      vecs[1] = mk(32'd0,          32'd1,          8'hFF, 32'hFFFFFFFF,   1'b1);
      vecs[2] = mk(32'd5,          32'd3,          8'h00, 32'hFFFFFFFB,   1'b1);
      vecs[3] = mk(32'd5,          32'd3,          8'h0F, 32'hFFFFFFF2,   1'b1);
      vecs[4] = mk(32'h000000FF,   32'd0,          8'h00, 32'h000000FF,   1'b0);
      vecs[5] = mk(32'd0,          32'd0,          8'h00, 32'hFFFFFFFF,   1'b1);
      vecs[6] = mk(32'h80000000,   32'd1,          8'hFF, 32'h7FFFFFFF,   1'b0);
      vecs[7] = mk(32'h12345678,   32'h12345678,   8'hFF, 32'd0,          1'b0);

      fork
         monitor_loop();
         random_ready_loop();
      join_none

      in_valid = 1'b1;
      repeat (3) step();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_diff", Diff, 32'd0);
      check("reset_borrow", {31'd0, Borrow}, 32'd0);
      check("reset_in_ready", {31'd0, in_ready}, 32'd1);

      // Latency: accepted at one edge, visible two edges later.
      drive(vecs[0]);
      @(negedge clk);
      check("lat_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("lat_n1_out_valid", {31'd0, out_valid}, 32'd0);
      step();
      check("lat_n2_out_valid", {31'd0, out_valid}, 32'd1);
      check("lat_n2_diff", Diff, 32'd7);
      step();

      // Table, back-to-back with the consumer always ready.
      for (int i = 0; i < 8; i++) send(vecs[i]);
      repeat (4) step();

      // Backpressure with Er changed while the first two are held.
      out_ready = 1'b0;
      drive(mk(32'd5, 32'd3, 8'hFF, 32'd2, 1'b0));
      @(negedge clk);
      check("bp_t1_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      drive(mk(32'd100, 32'd58, 8'hFF, 32'd42, 1'b0));
      @(negedge clk);
      check("bp_t2_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      drive(mk(32'd5, 32'd3, 8'h00, 32'hFFFFFFFB, 1'b1));
      for (int i = 0; i < 4; i++) begin
         check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_stall_out_valid", {31'd0, out_valid}, 32'd1);
         check("bp_stall_diff", Diff, 32'd2);
         check("bp_stall_borrow", {31'd0, Borrow}, 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_out2_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out2_diff", Diff, 32'd42);
      step();
      check("bp_out3_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out3_diff", Diff, 32'hFFFFFFFB);
      check("bp_out3_borrow", {31'd0, Borrow}, 32'd1);
      step();
      check("bp_drained_out_valid", {31'd0, out_valid}, 32'd0);

      // Reset with two transactions in flight and in_valid held high.
      out_ready = 1'b0;
      send(vecs[0]);
      send(vecs[1]);
      drive(vecs[6]);
      reset = 1'b1;
      step();
      check("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_mid_diff", Diff, 32'd0);
      check("rst_mid_borrow", {31'd0, Borrow}, 32'd0);
      check("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (8) step();
      check("rst_mid_no_output", {31'd0, out_valid}, 32'd0);
      send(vecs[2]);

      // Table again and random exact vectors under random backpressure.
      rand_ready_en = 1'b1;
      for (int i = 0; i < 8; i++) send(vecs[i]);
      for (int i = 0; i < 24; i++) begin
         v.a      = $urandom;
         v.b      = $urandom;
         v.er     = 8'hFF;
         v.diff   = v.a - v.b;
         v.borrow = (v.a < v.b);
         send(v);
      end
      rand_ready_en = 1'b0;
      out_ready     = 1'b1;

      n = 0;
      while (sb_q.size() != 0 && n < 100) begin
         step();
         n++;
      end
      check("drain_outstanding", sb_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
